pcie_status_led: RTL

//  Drives board status LEDs from PCIe core activity and error strobes; replaces constant LED ties in fpga_core.
//  Per-channel activity pulse stretching on green LEDs; error state machine on red LEDs.

---
 rtl/pcie_status_led_if.sv | 23 ++
 rtl/pcie_status_led.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pcie_status_led_if.sv
// Status LED bundle: activity/error strobes and mode in, LED drives and error state out.
interface pcie_status_led_if #(
    parameter int unsigned CH_COUNT = 8
);
    logic [CH_COUNT-1:0] act;
    logic                err_cor;
    logic                err_uncor;
    logic                err_clear;
    logic [1:0]          mode;
    logic [CH_COUNT-1:0] led_green;
    logic [CH_COUNT-1:0] led_red;
    logic [1:0]          err_state;

    modport master (
        output act, err_cor, err_uncor, err_clear, mode,
        input  led_green, led_red, err_state
    );

    modport slave (
        input  act, err_cor, err_uncor, err_clear, mode,
        output led_green, led_red, err_state
    );
endinterface

// File: rtl/pcie_status_led.sv
// Board status LEDs: stretched per-channel activity on green, error state machine on red,
// with a global lamp-test / dark / inverted override.
module pcie_status_led #(
    parameter int unsigned CH_COUNT       = 8,
    parameter int unsigned PRESCALE       = 250000,
    parameter int unsigned STRETCH_TICKS  = 30,
    parameter int unsigned BLINK_TICKS    = 250,
    parameter int unsigned ERR_HOLD_TICKS = 1000
) (
    input logic              clk,
    input logic              rst,
    pcie_status_led_if.slave bus
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned SW = $clog2(STRETCH_TICKS + 1);
    localparam int unsigned HW = $clog2(ERR_HOLD_TICKS + 1);
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COR   = 2'd1,
        ST_UNCOR = 2'd2
    } err_state_t;

    logic [PW-1:0]       pcnt;
    logic                tick_c;
    logic [SW-1:0]       scnt   [CH_COUNT];
    logic [SW-1:0]       scnt_n [CH_COUNT];
    logic [CH_COUNT-1:0] active_c;

    err_state_t          state, state_n;
    logic [HW-1:0]       hold, hold_n;
    logic [BW-1:0]       bcnt, bcnt_n, bcnt_step;
    logic                phase, phase_n, phase_step;
    logic [CH_COUNT-1:0] red_c;

    assign tick_c = (pcnt == PW'(PRESCALE - 1));

    // Per-channel stretch: a new strobe always reloads, ticks only drain.
    always_comb begin
        for (int i = 0; i < CH_COUNT; i++) begin
            scnt_n[i] = scnt[i];
            if (bus.act[i]) begin
                scnt_n[i] = SW'(STRETCH_TICKS);
            end else if (tick_c && (scnt[i] != '0)) begin
                scnt_n[i] = scnt[i] - SW'(1);
            end
            active_c[i] = (scnt_n[i] != '0);
        end
    end

    // Blink advance used while sitting in UNCOR.
    always_comb begin
        bcnt_step  = bcnt;
        phase_step = phase;
        if (tick_c) begin
            if (bcnt == BW'(BLINK_TICKS - 1)) begin
                bcnt_step  = '0;
                phase_step = ~phase;
            end else begin
                bcnt_step = bcnt + BW'(1);
            end
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold;
        bcnt_n  = bcnt;
        phase_n = phase;
        if (bus.err_uncor) begin
            state_n = ST_UNCOR;
            hold_n  = '0;
            if (state != ST_UNCOR) begin
                bcnt_n  = '0;
                phase_n = 1'b1;
            end else begin
                bcnt_n  = bcnt_step;
                phase_n = phase_step;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.err_cor) begin
                        state_n = ST_COR;
                        hold_n  = HW'(ERR_HOLD_TICKS);
                    end
                end
                ST_COR: begin
                    if (bus.err_clear) begin
                        state_n = ST_IDLE;
                        hold_n  = '0;
                    end else if (bus.err_cor) begin
                        hold_n = HW'(ERR_HOLD_TICKS);
                    end else if (tick_c) begin
                        if (hold <= HW'(1)) begin
                            state_n = ST_IDLE;
                            hold_n  = '0;
                        end else begin
                            hold_n = hold - HW'(1);
                        end
                    end
                end
                ST_UNCOR: begin
                    if (bus.err_clear) begin
                        state_n = ST_IDLE;
                        bcnt_n  = '0;
                        phase_n = 1'b0;
                    end else begin
                        bcnt_n  = bcnt_step;
                        phase_n = phase_step;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    hold_n  = '0;
                    bcnt_n  = '0;
                    phase_n = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (state_n)
            ST_COR:   red_c = '1;
            ST_UNCOR: red_c = {CH_COUNT{phase_n}};
            default:  red_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt          <= '0;
            state         <= ST_IDLE;
            hold          <= '0;
            bcnt          <= '0;
            phase         <= 1'b0;
            bus.led_green <= '0;
            bus.led_red   <= '0;
            bus.err_state <= 2'd0;
            for (int i = 0; i < CH_COUNT; i++) begin
                scnt[i] <= '0;
            end
        end else begin
            pcnt  <= tick_c ? '0 : pcnt + PW'(1);
            state <= state_n;
            hold  <= hold_n;
            bcnt  <= bcnt_n;
            phase <= phase_n;
            for (int i = 0; i < CH_COUNT; i++) begin
                scnt[i] <= scnt_n[i];
            end
            bus.err_state <= 2'(state_n);
            case (bus.mode)
                2'd1: begin
                    bus.led_green <= '0;
                    bus.led_red   <= '0;
                end
                2'd2: begin
                    bus.led_green <= '1;
                    bus.led_red   <= '1;
                end
                2'd3: begin
                    bus.led_green <= ~active_c;
                    bus.led_red   <= red_c;
                end
                default: begin
                    bus.led_green <= active_c;
                    bus.led_red   <= red_c;
                end
            endcase
        end
    end
endmodule
